// File: rtl/arb_rr_v2.sv
// Registered round-robin arbiter with rotating priority pointer and flop-driven grant outputs.
// Optional hold budget per ownership is compiled in when ARB_HOLD_LIMIT_EN is defined.
module arb_rr_v2 #(
    parameter int NUM_PORTS = 8,
    parameter int MAX_HOLD  = 16,
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 done_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 gnt_valid_o
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_GRANT = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
    localparam logic [IDX_W:0]   PORTS_W  = (IDX_W + 1)'(NUM_PORTS);

    if (NUM_PORTS < 1 || NUM_PORTS > 64) begin : g_bad_ports
        $error("arb_rr_v2: NUM_PORTS out of range 1..64");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("arb_rr_v2: MAX_HOLD out of range 1..255");
    end

    logic [0:0]             state;
    logic [IDX_W-1:0]       ptr;
    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [IDX_W-1:0]       win_off;
    logic [IDX_W:0]         win_sum;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [NUM_PORTS-1:0]   win_onehot;
    logic                   owner_req;
    logic                   hold_hit;
    logic                   release_now;
    logic [IDX_W-1:0]       ptr_next;

    // Rotate requests so the pointer position lands at bit 0; the lowest set bit is then the winner's offset.
    assign req_dbl = {req_i, req_i} >> ptr;
    assign req_rot = req_dbl[NUM_PORTS-1:0];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        win_off = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_rot[k]) win_off = k[IDX_W-1:0];
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= PORTS_W) win_sum = win_sum - PORTS_W;
        win_idx = win_sum[IDX_W-1:0];
    end

    assign win_found  = |req_i;
    assign win_onehot = NUM_PORTS'(1) << win_idx;

    assign owner_req   = |(req_i & gnt_o);
    assign release_now = done_i | ~owner_req | hold_hit;
    assign ptr_next    = (gnt_idx_o == LAST_IDX) ? '0 : gnt_idx_o + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt;

    assign hold_hit = (hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == ST_IDLE) begin
            hold_cnt <= win_found ? 8'd1 : 8'd0;
        end else if (release_now) begin
            hold_cnt <= '0;
        end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state       <= ST_GRANT;
                        gnt_o       <= win_onehot;
                        gnt_idx_o   <= win_idx;
                        gnt_valid_o <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // All release causes collapse into one event, so the pointer advances exactly once.
                    if (release_now) begin
                        state       <= ST_IDLE;
                        ptr         <= ptr_next;
                        gnt_o       <= '0;
                        gnt_idx_o   <= '0;
                        gnt_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    gnt_o       <= '0;
                    gnt_idx_o   <= '0;
                    gnt_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_v2.sv
// Self-checking bench for arb_rr_v2: directed scenarios plus random traffic against a
// behavioural model of the round-robin rules (owner/pointer tracked as plain integers).
module tb_arb_rr_v2;

    localparam int NP = 8;
    localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] req_i;
    logic          done_i;
    logic [NP-1:0] gnt_o;
    logic [2:0]    gnt_idx_o;
    logic          gnt_valid_o;

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    arb_rr_v2 #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the owner is found by walking ports from the pointer, modulo NP.
    task automatic model_update(input logic r, input logic [NP-1:0] q, input logic d);
        if (!r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_ptr + k) % NP;
                if (m_owner < 0 && q[p]) begin
                    m_owner = p;
                    m_hold  = 1;
                end
            end
        end else begin
            if (d || !q[m_owner] || (HOLD_EN && m_hold == MH)) begin
                m_ptr   = (m_owner + 1) % NP;
                m_owner = -1;
                m_hold  = 0;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [NP-1:0] q, input logic d);
        logic [63:0] exp_gnt;
        logic [63:0] exp_idx;
        rst_n  = r;
        req_i  = q;
        done_i = d;
        @(posedge clk);
        model_update(r, q, d);
        #1;
        exp_gnt = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
        exp_idx = (m_owner >= 0) ? 64'(m_owner) : 64'd0;
        check("model_gnt", 64'(gnt_o), exp_gnt);
        check("model_idx", 64'(gnt_idx_o), exp_idx);
        check("model_valid", 64'(gnt_valid_o), 64'(m_owner >= 0));
        check("onehot0", 64'($onehot0(gnt_o)), 64'd1);
    endtask

    logic [NP-1:0] seq1 [7];
    logic [NP-1:0] rq;

    initial begin
        rst_n  = 1'b0;
        req_i  = '0;
        done_i = 1'b0;

        // Reset holds everything at zero regardless of requests.
        step(1'b0, 8'hFF, 1'b1);
        step(1'b0, 8'hFF, 1'b0);
        check("reset_gnt", 64'(gnt_o), 64'd0);
        check("reset_valid", 64'(gnt_valid_o), 64'd0);
        check("reset_idx", 64'(gnt_idx_o), 64'd0);

        // Rotation across 4,5,7 with a done pulse after each grant.
        seq1[0] = 8'h10; seq1[1] = 8'h00; seq1[2] = 8'h20; seq1[3] = 8'h00;
        seq1[4] = 8'h80; seq1[5] = 8'h00; seq1[6] = 8'h10;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'b1011_0000, (i % 2) == 1);
            check($sformatf("rotate_%0d", i), 64'(gnt_o), 64'(seq1[i]));
        end

        // Owner drops its request after three grant cycles.
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h01, 1'b0);
            check("drop_hold", 64'(gnt_o), 64'h01);
        end
        step(1'b1, 8'h00, 1'b0);
        check("drop_release", 64'(gnt_o), 64'h00);
        step(1'b1, 8'h03, 1'b0);
        check("drop_ptr_next", 64'(gnt_o), 64'h02);

        // Two ports held continuously with done low.
        step(1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            logic [NP-1:0] e;
`ifdef ARB_HOLD_LIMIT_EN
            if (i <= 4) e = 8'h01;
            else if (i == 5 || i == 10) e = 8'h00;
            else if (i <= 9) e = 8'h02;
            else e = 8'h01;
`else
            e = 8'h01;
`endif
            step(1'b1, 8'h03, 1'b0);
            check($sformatf("hold_%0d", i), 64'(gnt_o), 64'(e));
        end

        // Reset in the middle of a grant to port 5.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        check("midrst_own5", 64'(gnt_idx_o), 64'd5);
        step(1'b1, 8'h20, 1'b0);
        step(1'b0, 8'h21, 1'b0);
        check("midrst_cleared", 64'(gnt_o), 64'h00);
        step(1'b1, 8'h21, 1'b0);
        check("midrst_ptr0", 64'(gnt_o), 64'h01);

        // done and request drop together: one release, pointer moves to 3.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        check("simul_own2", 64'(gnt_o), 64'h04);
        step(1'b1, 8'h08, 1'b1);
        check("simul_bubble", 64'(gnt_o), 64'h00);
        step(1'b1, 8'h08, 1'b0);
        check("simul_gnt3", 64'(gnt_o), 64'h08);

        // Release port 3, then idle with done toggling; pointer must stay at 4.
        step(1'b1, 8'h08, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 8'h00, (i % 2) == 0);
            check("idle_valid", 64'(gnt_valid_o), 64'd0);
        end
        step(1'b1, 8'hFF, 1'b0);
        check("idle_ptr_kept", 64'(gnt_o), 64'h10);

        // Random traffic against the model.
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rq = 8'($urandom);
            if ($urandom_range(0, 2) == 0) rq = rq & 8'($urandom);
            if ($urandom_range(0, 9) == 0) rq = '0;
            step($urandom_range(0, 99) != 0, rq, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
